// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for a multicycle MIPS datapath over one shared instruction/data memory.
// Memory req/ready handshake with a stall timeout; outputs decode the state (plus mem_ready/zero/op where noted).
module multicycle_ctrl_fsm #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             instr_retired,
  output logic             illegal_op,
  output logic             bus_error,
  output logic [CNT_W-1:0] retire_count
);

  localparam int WCW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WCW-1:0] LIM = WCW'(WAIT_LIMIT);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP
  } state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           mem_state;
  logic           timeout;
  logic           pc_write;
  logic           branch;

  assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  // With WAIT_LIMIT=0 the counter never leaves 0, so the limit term disables the timeout
  assign timeout   = (WAIT_LIMIT != 0) && mem_state && !mem_ready && (wait_cnt == LIM);

  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_control   = ALU_AND;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    instr_retired = 1'b0;
    illegal_op    = 1'b0;
    if (reset_n) begin
      case (state)
        FETCH: begin
          mem_req     = 1'b1;
          alu_src_b   = 2'b01;
          alu_control = ALU_ADD;
          ir_write    = mem_ready;
          pc_write    = mem_ready;
        end
        DECODE: begin
          alu_src_b   = 2'b11;
          alu_control = ALU_ADD;
          illegal_op  = !(op == OP_R || op == OP_LW || op == OP_SW ||
                          op == OP_ADDI || op == OP_BEQ || op == OP_J);
        end
        MEMADR, ADDIEX: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = ALU_ADD;
        end
        MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        MEMWB: begin
          reg_write     = 1'b1;
          mem_to_reg    = 1'b1;
          instr_retired = 1'b1;
        end
        MEMWR: begin
          mem_req       = 1'b1;
          mem_write     = 1'b1;
          i_or_d        = 1'b1;
          instr_retired = mem_ready;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          case (funct)
            6'b100000: alu_control = ALU_ADD;
            6'b100010: alu_control = ALU_SUB;
            6'b100100: alu_control = ALU_AND;
            6'b100101: alu_control = ALU_OR;
            6'b101010: alu_control = ALU_SLT;
            default:   alu_control = 3'b000;
          endcase
        end
        ALUWB: begin
          reg_write     = 1'b1;
          reg_dst       = 1'b1;
          instr_retired = 1'b1;
        end
        ADDIWB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_control   = ALU_SUB;
          branch        = 1'b1;
          pc_src        = 2'b01;
          instr_retired = 1'b1;
        end
        JUMP: begin
          pc_write      = 1'b1;
          pc_src        = 2'b10;
          instr_retired = 1'b1;
        end
        default: ;
      endcase
    end
    bus_error = reset_n && timeout;
    pc_en     = pc_write | (branch & zero);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= FETCH;
      wait_cnt     <= '0;
      retire_count <= '0;
    end else begin
      if (instr_retired)
        retire_count <= retire_count + CNT_W'(1);
      // Saturates at the limit; any completion, timeout or state change clears it
      if (mem_state && !mem_ready && wait_cnt != LIM)
        wait_cnt <= wait_cnt + WCW'(1);
      else
        wait_cnt <= '0;
      case (state)
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXEC;
            OP_ADDI:      state <= ADDIEX;
            OP_BEQ:       state <= BRANCH;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: state <= (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD: begin
          if (mem_ready)    state <= MEMWB;
          else if (timeout) state <= FETCH;
        end
        MEMWR:  if (mem_ready || timeout) state <= FETCH;
        EXEC:   state <= ALUWB;
        ADDIEX: state <= ADDIWB;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench: default instance plus a WAIT_LIMIT=3 / CNT_W=2 instance sharing the same inputs.
module tb_multicycle_ctrl_fsm;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;

  logic mem_req, mem_write, i_or_d, ir_write, pc_en, alu_src_a;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_control;
  logic reg_write, reg_dst, mem_to_reg, instr_retired, illegal_op, bus_error;
  logic [31:0] retire_count;

  logic mem_req_b, mem_write_b, i_or_d_b, ir_write_b, pc_en_b, alu_src_a_b;
  logic [1:0] pc_src_b, alu_src_b_b;
  logic [2:0] alu_control_b;
  logic reg_write_b, reg_dst_b, mem_to_reg_b, instr_retired_b, illegal_op_b, bus_error_b;
  logic [1:0] retire_count_b;

  multicycle_ctrl_fsm dut (
    .clock(clock), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_retired(instr_retired),
    .illegal_op(illegal_op), .bus_error(bus_error), .retire_count(retire_count)
  );

  multicycle_ctrl_fsm #(.WAIT_LIMIT(3), .CNT_W(2)) dut3 (
    .clock(clock), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_b), .mem_write(mem_write_b), .i_or_d(i_or_d_b), .ir_write(ir_write_b), .pc_en(pc_en_b),
    .pc_src(pc_src_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_control(alu_control_b),
    .reg_write(reg_write_b), .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .instr_retired(instr_retired_b),
    .illegal_op(illegal_op_b), .bus_error(bus_error_b), .retire_count(retire_count_b)
  );

  always #5 clock = ~clock;

  logic [18:0] outs, outs_b;
  assign outs = {mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                 alu_control, reg_write, reg_dst, mem_to_reg, instr_retired, illegal_op, bus_error};
  assign outs_b = {mem_req_b, mem_write_b, i_or_d_b, ir_write_b, pc_en_b, pc_src_b, alu_src_a_b, alu_src_b_b,
                   alu_control_b, reg_write_b, reg_dst_b, mem_to_reg_b, instr_retired_b, illegal_op_b, bus_error_b};

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [6:0] snap;
  logic [1:0] dec_srcb;
  logic [2:0] alu3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  // Entered just after the posedge that starts FETCH; returns just after the posedge of the next FETCH
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
    cyc = 0; snap = '0; dec_srcb = '0; alu3 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 2) dec_srcb = alu_src_b;
      if (i == 3) alu3 = alu_control;
      if (instr_retired) begin
        cyc = i;
        snap = {pc_en, pc_src, reg_write, reg_dst, mem_to_reg, mem_write};
        break;
      end
    end
    next_cyc();
  endtask

  initial begin
    int wr, rets, errs;
    logic [3:0] be;
    // Reset: everything forced low
    repeat (2) begin
      @(negedge clock);
      chk("reset_outs", 32'(outs), 32'd0);
      chk("reset_outs_b", 32'(outs_b), 32'd0);
    end
    chk("reset_count", retire_count, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    chk("fetch_req_ir_pc", 32'({mem_req, ir_write, pc_en}), 32'b111);
    chk("fetch_alu", 32'({alu_src_a, alu_src_b, alu_control}), 32'b0_01_010);

    // Program with mem_ready tied high
    run_instr(6'b001000, 6'd0, 1'b0);
    chk("addi_cyc", cyc, 4);
    chk("addi_ret", 32'(snap), 32'b0_00_1_0_0_0);
    chk("decode_srcb", 32'(dec_srcb), 32'b11);
    run_instr(6'b101011, 6'd0, 1'b0);
    chk("sw_cyc", cyc, 4);
    chk("sw_ret", 32'(snap), 32'b0_00_0_0_0_1);
    run_instr(6'b100011, 6'd0, 1'b0);
    chk("lw_cyc", cyc, 5);
    chk("lw_ret", 32'(snap), 32'b0_00_1_0_1_0);
    run_instr(6'b000000, 6'b100010, 1'b0);
    chk("sub_cyc", cyc, 4);
    chk("sub_alu", 32'(alu3), 32'b110);
    chk("sub_ret", 32'(snap), 32'b0_00_1_1_0_0);
    run_instr(6'b000100, 6'd0, 1'b1);
    chk("beq_t_cyc", cyc, 3);
    chk("beq_t_ret", 32'(snap), 32'b1_01_0_0_0_0);
    run_instr(6'b000010, 6'd0, 1'b0);
    chk("j_cyc", cyc, 3);
    chk("j_ret", 32'(snap), 32'b1_10_0_0_0_0);
    chk("count6", retire_count, 32'd6);
    chk("count_wrap", 32'(retire_count_b), 32'd2);

    // Branch not taken, and funct decode corners
    run_instr(6'b000100, 6'd0, 1'b0);
    chk("beq_nt_cyc", cyc, 3);
    chk("beq_nt_ret", 32'(snap), 32'b0_01_0_0_0_0);
    run_instr(6'b000000, 6'b101010, 1'b0);
    chk("slt_alu", 32'(alu3), 32'b111);
    run_instr(6'b000000, 6'b100101, 1'b0);
    chk("or_alu", 32'(alu3), 32'b001);
    run_instr(6'b000000, 6'b000000, 1'b0);
    chk("unk_funct_alu", 32'(alu3), 32'b000);
    chk("unk_funct_cyc", cyc, 4);
    chk("count10", retire_count, 32'd10);

    // SW stalled 7 cycles then completes
    op = 6'b101011;
    repeat (3) next_cyc();
    mem_ready = 1'b0;
    wr = 0; rets = 0; errs = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) mem_ready = 1'b1;
      @(negedge clock);
      if (mem_req && mem_write) wr++;
      if (instr_retired) rets++;
      if (bus_error) errs++;
      next_cyc();
    end
    chk("sw_stall_wr", wr, 8);
    chk("sw_stall_ret", rets, 1);
    chk("sw_stall_err", errs, 0);
    chk("count11", retire_count, 32'd11);

    // Fetch timeout on the WAIT_LIMIT=3 instance
    reset_n = 1'b0;
    mem_ready = 1'b0;
    next_cyc();
    reset_n = 1'b1;
    be = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      be[i] = bus_error_b;
      if (bus_error) errs++;
      next_cyc();
    end
    chk("timeout_pulse", 32'(be), 32'b1000);
    @(negedge clock);
    chk("after_timeout", 32'({mem_req_b, ir_write_b, bus_error_b, i_or_d_b}), 32'b1000);
    chk("timeout_count", 32'(retire_count_b), 32'd0);
    repeat (3) next_cyc();
    // Limit reached with mem_ready arriving the same cycle: completion wins
    mem_ready = 1'b1;
    op = 6'b111111;
    @(negedge clock);
    chk("limit_ready", 32'({bus_error_b, ir_write_b}), 32'b01);
    chk("no_err_default", errs, 0);
    next_cyc();

    // Illegal opcode in DECODE
    @(negedge clock);
    chk("illegal", 32'({illegal_op, instr_retired, illegal_op_b}), 32'b101);
    next_cyc();
    @(negedge clock);
    chk("illegal_to_fetch", 32'({mem_req, i_or_d, ir_write, illegal_op}), 32'b1010);
    chk("illegal_no_ret", retire_count, 32'd0);

    // Reset during MEMRD
    op = 6'b100011;
    repeat (3) next_cyc();
    @(negedge clock);
    chk("in_memrd", 32'({mem_req, i_or_d, mem_write}), 32'b110);
    reset_n = 1'b0;
    #1;
    chk("memrd_reset_outs", 32'(outs), 32'd0);
    next_cyc();
    reset_n = 1'b1;
    #1;
    chk("reset_to_fetch", 32'({mem_req, i_or_d, alu_src_b, reg_write}), 32'b10_01_0);
    chk("reset_count_clr", retire_count, 32'd0);
    run_instr(6'b001000, 6'd0, 1'b0);
    chk("post_reset_addi", cyc, 4);
    chk("count1", retire_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
